// File: rtl/swi_pkg.sv
// Shared constants and types for the slide-switch reader.
package swi_pkg;

  localparam int unsigned ACC_W       = 64;
  localparam int unsigned NIB_W       = 4;
  localparam int unsigned MAX_NIBBLES = 16;
  localparam int unsigned ACC_CNT_W   = 5;

  typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/swi_debounce_bit.sv
// One switch bit: two-flop synchroniser, persistence counter and
// registered rise/fall pulse generation.
module swi_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new synchronised value only after it has persisted long enough;
  // any return to the held value restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and pulse registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/swi_reader.sv
// Slide-switch reader: per-bit debounce with edge pulses, plus a hex-entry
// accumulator driven by the ENTER and CLEAR switches.
module swi_reader
  import swi_pkg::*;
#(
  parameter int unsigned NBITS           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ENTER_BIT       = 7,
  parameter int unsigned CLEAR_BIT       = 6
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic [NBITS-1:0]     SWI,
  output logic [NBITS-1:0]     swi_stable,
  output logic [NBITS-1:0]     swi_rise,
  output logic [NBITS-1:0]     swi_fall,
  output acc_t                 acc,
  output logic [ACC_CNT_W-1:0] acc_count,
  output logic                 acc_full,
  output logic                 acc_strobe
);

  localparam logic [ACC_CNT_W-1:0] CNT_FULL = ACC_CNT_W'(MAX_NIBBLES);

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    swi_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_2 (clk_2),
      .reset (reset),
      .raw   (SWI[i]),
      .stable(swi_stable[i]),
      .rise  (swi_rise[i]),
      .fall  (swi_fall[i])
    );
  end

  acc_t                 acc_q, acc_d;
  logic [ACC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 strobe_q, strobe_d;

  // CLEAR takes priority over ENTER; ENTER shifts in the debounced low nibble,
  // which already reflects a low-nibble change accepted alongside ENTER.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (swi_rise[CLEAR_BIT]) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (swi_rise[ENTER_BIT]) begin
      acc_d    = {acc_q[ACC_W-NIB_W-1:0], swi_stable[NIB_W-1:0]};
      cnt_d    = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + ACC_CNT_W'(1);
      strobe_d = 1'b1;
    end
    full_d = (cnt_d == CNT_FULL);
  end

  // Accumulator registers.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      strobe_q <= strobe_d;
    end
  end

  assign acc        = acc_q;
  assign acc_count  = cnt_q;
  assign acc_full   = full_q;
  assign acc_strobe = strobe_q;

endmodule

// File: tb/tb_swi_reader.sv
// Testbench for swi_reader: scoreboards for debounced edge events and
// accumulator strobes, plus directed checks around reset and clear.
module tb_swi_reader;

  logic        clk_2 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  SWI   = 8'h00;
  logic [7:0]  swi_stable, swi_rise, swi_fall;
  logic [63:0] acc;
  logic [4:0]  acc_count;
  logic        acc_full, acc_strobe;

  swi_reader #(
    .NBITS          (8),
    .DEBOUNCE_CYCLES(4),
    .ENTER_BIT      (7),
    .CLEAR_BIT      (6)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .SWI       (SWI),
    .swi_stable(swi_stable),
    .swi_rise  (swi_rise),
    .swi_fall  (swi_fall),
    .acc       (acc),
    .acc_count (acc_count),
    .acc_full  (acc_full),
    .acc_strobe(acc_strobe)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
  } edge_exp_t;

  typedef struct {
    logic [63:0] acc;
    logic [4:0]  cnt;
    logic        full;
  } acc_exp_t;

  edge_exp_t   edge_q[$];
  acc_exp_t    acc_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned strobes_seen = 0;

  logic [7:0]  cur_swi   = 8'h00;
  logic [63:0] model_acc = '0;
  logic [4:0]  model_cnt = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Edge monitor: every debounced pulse must match the next expected event.
  always @(negedge clk_2) begin
    if (!reset && ((swi_rise | swi_fall) != 8'h00)) begin
      if (edge_q.size() == 0) begin
        check_eq("unexp_rise", swi_rise, 8'h00);
        check_eq("unexp_fall", swi_fall, 8'h00);
      end else begin
        edge_exp_t e;
        e = edge_q.pop_front();
        check_eq("edge_stable", swi_stable, e.stable);
        check_eq("edge_rise", swi_rise, e.rise);
        check_eq("edge_fall", swi_fall, e.fall);
      end
    end
  end

  // Strobe monitor: every accumulator strobe must match the next expected entry.
  always @(negedge clk_2) begin
    if (!reset && acc_strobe) begin
      strobes_seen++;
      if (acc_q.size() == 0) begin
        check_eq("unexp_strobe", acc_strobe, 1'b0);
      end else begin
        acc_exp_t a;
        a = acc_q.pop_front();
        check_eq("strobe_acc", acc, a.acc);
        check_eq("strobe_cnt", acc_count, a.cnt);
        check_eq("strobe_full", acc_full, a.full);
      end
    end
  end

  // Drive a new switch value, predict its debounced edges and accumulator
  // effect, and let it settle.
  task automatic set_swi(input logic [7:0] v);
    edge_exp_t e;
    acc_exp_t  a;
    logic [7:0] r;
    @(posedge clk_2); #1;
    r = v & ~cur_swi;
    if (v != cur_swi) begin
      e.stable = v;
      e.rise   = r;
      e.fall   = ~v & cur_swi;
      edge_q.push_back(e);
    end
    if (r[6]) begin
      model_acc = '0;
      model_cnt = '0;
    end else if (r[7]) begin
      model_acc = {model_acc[59:0], v[3:0]};
      if (model_cnt != 5'd16) model_cnt = model_cnt + 5'd1;
      a.acc  = model_acc;
      a.cnt  = model_cnt;
      a.full = (model_cnt == 5'd16);
      acc_q.push_back(a);
    end
    cur_swi = v;
    SWI     = v;
    repeat (9) @(posedge clk_2);
  endtask

  task automatic enter_nibble(input logic [3:0] nib);
    set_swi({4'h0, nib});
    set_swi({4'h8, nib});
    set_swi({4'h0, nib});
  endtask

  initial begin
    int unsigned s0;

    // Reset held over the first edges.
    repeat (3) @(posedge clk_2);
    @(negedge clk_2);
    check_eq("rst_stable", swi_stable, 8'h00);
    check_eq("rst_rise", swi_rise, 8'h00);
    check_eq("rst_fall", swi_fall, 8'h00);
    check_eq("rst_acc", acc, 64'h0);
    check_eq("rst_cnt", acc_count, 5'd0);
    check_eq("rst_full", acc_full, 1'b0);
    check_eq("rst_strobe", acc_strobe, 1'b0);
    reset = 1'b0;

    // Reset pulse while the bit-4 counter sits at 2 discards the change.
    @(posedge clk_2); #1;
    SWI = 8'h10;
    repeat (4) @(posedge clk_2);
    #1;
    reset = 1'b1;
    SWI   = 8'h00;
    repeat (2) @(posedge clk_2);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk_2);
    @(negedge clk_2);
    check_eq("midrst_stable", swi_stable, 8'h00);

    // Exact debounce latency on bit 0.
    begin
      edge_exp_t e;
      @(posedge clk_2); #1;
      SWI = 8'h01;
      cur_swi = 8'h01;
      e.stable = 8'h01; e.rise = 8'h01; e.fall = 8'h00;
      edge_q.push_back(e);
      repeat (5) @(posedge clk_2);
      @(negedge clk_2);
      check_eq("lat_before", swi_stable, 8'h00);
      @(posedge clk_2);
      @(negedge clk_2);
      check_eq("lat_at", swi_stable, 8'h01);
      check_eq("lat_rise", swi_rise, 8'h01);
      repeat (4) @(posedge clk_2);
    end
    set_swi(8'h00);

    // A 3-cycle glitch on bit 2 never reaches the debounced output.
    @(posedge clk_2); #1;
    SWI = 8'h04;
    repeat (3) @(posedge clk_2);
    #1;
    SWI = 8'h00;
    repeat (10) @(posedge clk_2);
    @(negedge clk_2);
    check_eq("glitch_stable", swi_stable, 8'h00);

    // Hex entry of A, B, C.
    s0 = strobes_seen;
    enter_nibble(4'hA);
    enter_nibble(4'hB);
    enter_nibble(4'hC);
    @(negedge clk_2);
    check_eq("abc_acc", acc, 64'hABC);
    check_eq("abc_cnt", acc_count, 5'd3);
    check_eq("abc_strobes", strobes_seen - s0, 3);

    // Clear, then saturate with 17 entries.
    set_swi(8'h40);
    set_swi(8'h00);
    @(negedge clk_2);
    check_eq("clr_acc", acc, 64'h0);
    check_eq("clr_cnt", acc_count, 5'd0);
    check_eq("clr_full", acc_full, 1'b0);
    for (int unsigned i = 1; i <= 16; i++) enter_nibble(4'(i));
    @(negedge clk_2);
    check_eq("sat16_acc", acc, 64'h123456789ABCDEF0);
    check_eq("sat16_full", acc_full, 1'b1);
    enter_nibble(4'h5);
    @(negedge clk_2);
    check_eq("sat17_acc", acc, 64'h23456789ABCDEF05);
    check_eq("sat17_cnt", acc_count, 5'd16);

    // ENTER and CLEAR rising together: clear only, no strobe.
    s0 = strobes_seen;
    set_swi(8'hC3);
    @(negedge clk_2);
    check_eq("both_acc", acc, 64'h0);
    check_eq("both_cnt", acc_count, 5'd0);
    check_eq("both_full", acc_full, 1'b0);
    check_eq("both_strobes", strobes_seen - s0, 0);
    set_swi(8'h00);

    repeat (5) @(posedge clk_2);
    check_eq("edge_q_left", edge_q.size(), 0);
    check_eq("acc_q_left", acc_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/swi_reader.md
Name: swi_reader

Overview:
- Input-side counterpart to the display path: the display path turns internal state into LED/SEG/LCD, and this block turns raw slide-switch input into clean, usable events.
- Synchronises and debounces the 8-bit SWI vector and emits per-bit rise/fall pulses.
- Runs a hex-entry accumulator that shifts one nibble per ENTER press into a 64-bit value suitable for driving LCD.
- Sits between the board/simulator SWI pins and user logic in top.

Parameters:
- NBITS, 8, width of switch vector.
- DEBOUNCE_CYCLES, 4, consecutive cycles a changed synchronised value must persist before acceptance; legal range 1..2^16-1.
- ENTER_BIT, 7, SWI index whose debounced rising edge shifts a nibble in.
- CLEAR_BIT, 6, SWI index whose debounced rising edge clears the accumulator.

Ports:
- clk_2  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- SWI  input  NBITS  raw switch inputs, asynchronous to clk_2.
- swi_stable  output  NBITS  debounced switch value.
- swi_rise  output  NBITS  one-cycle pulse per bit on debounced 0->1.
- swi_fall  output  NBITS  one-cycle pulse per bit on debounced 1->0.
- acc  output  64  accumulated hex value; newest nibble in acc[3:0].
- acc_count  output  5  nibbles entered, saturating at 16.
- acc_full  output  1  acc_count == 16.
- acc_strobe  output  1  one-cycle pulse when a nibble is shifted in.

Behaviour:
- Reset: clk_2 and reset are the only clock and reset; reset is asynchronous and active-high. While reset is high, all of the following are 0: sync flops, swi_stable, counters, swi_rise, swi_fall, acc, acc_count, acc_full, acc_strobe. Reset asserted mid-debounce or mid-entry discards all progress immediately, with no pulse emitted.
- Synchroniser: two-flop chain per bit (sync1, sync2).
- Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES)+1, evaluated each clk_2 edge:
  - sync2 == swi_stable: cnt <= 0.
  - sync2 != swi_stable and cnt == DEBOUNCE_CYCLES-1: swi_stable <= sync2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Latency: a clean SWI change sampled at edge k appears in swi_stable after edge k+1+DEBOUNCE_CYCLES. With default 4, that is the 6th edge.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES cycles in sync2 resets cnt and never reaches swi_stable.
- Edge pulses:
  - swi_rise[i] and swi_fall[i] are registered and go high in the same cycle the new swi_stable value becomes visible, for exactly one cycle.
  - Never both high for one bit in the same cycle.
- Accumulator, evaluated on the same edge using the next swi_stable and next swi_rise values:
  - swi_rise[CLEAR_BIT]: acc <= 0, acc_count <= 0, acc_strobe <= 0.
  - Else swi_rise[ENTER_BIT]: acc <= {acc[59:0], new swi_stable[3:0]}, acc_count <= min(acc_count+1, 16), acc_strobe <= 1.
  - Else: acc_strobe <= 0 and acc and acc_count hold.
  - Net effect: acc, acc_count and acc_strobe update the cycle after the corresponding swi_rise pulse is visible.
- Simultaneous CLEAR and ENTER rise: CLEAR wins and no strobe is emitted.
- Full (acc_count == 16): further ENTERs keep shifting, dropping acc[63:60], strobe still pulses, and acc_count stays 16.
- Nibble source: the nibble comes from swi_stable[3:0] at the time of the ENTER rise. Bits 3:0 changing in the same debounce window as ENTER use their newly accepted value; otherwise they use the held value.
- acc_full is registered and equals (acc_count == 16) in the same cycle.
- Fall pulses on ENTER_BIT or CLEAR_BIT have no accumulator effect.

Decomposition:
- Package swi_pkg holds:
  - ACC_W = 64, NIB_W = 4, MAX_NIBBLES = 16, ACC_CNT_W = 5.
  - typedef acc_t (logic [63:0]).
- Sub-module swi_debounce_bit (clk_2, reset, raw, stable, rise, fall) holds one synchroniser, counter and edge generator. It is instantiated NBITS times via generate. The accumulator lives in swi_reader.

Test Plan:
- Reset mid-operation: hold reset during the first 3 edges, then SWI=8'h00 -> all outputs 0. Pulse reset while a debounce cnt is 2 -> swi_stable stays at its reset value and no pulses occur.
- Debounce latency: from SWI=0, set SWI=8'h01 before edge 0 -> swi_stable=8'h01 after edge 5 (DEBOUNCE_CYCLES=4), swi_rise=8'h01 for exactly that cycle; then SWI=0 -> swi_fall=8'h01 after the same latency.
- Glitch rejection: SWI[2] high for 3 cycles then low -> swi_stable[2] stays 0 and swi_rise[2] never asserts.
- Hex entry: enter nibbles A, B, C (set SWI[3:0], wait, toggle SWI[7] 0->1->0) -> acc=64'hABC, acc_count=3, three single-cycle acc_strobe pulses.
- Saturation: 17 ENTERs with nibbles 1..F,0,5 -> after the 16th ENTER acc=64'h123456789ABCDEF0 and acc_full=1; after the 17th acc=64'h23456789ABCDEF05 and acc_count=16.
- Clear: SWI[6] rise -> acc=0, acc_count=0, acc_full=0. Raw SWI[7] and SWI[6] rising in the same cycle (identical debounce timing) -> clear only, and acc_strobe stays 0.
